// File: rtl/sram_mp_ctrl.sv
// Multi-port controller for an external asynchronous SRAM.
// Round-robin arbitration across NPORTS requesters, one access at a time.
// SETUP / STROBE / DONE sequencing with configurable read and write wait states.
// Every pad-facing output and status output comes straight from a flop.
module sram_mp_ctrl #(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NPORTS  = 2,
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 1
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic [NPORTS-1:0]        req,
  input  logic [NPORTS-1:0]        we,
  input  logic [NPORTS*ADDR_W-1:0] addr,
  input  logic [NPORTS*DATA_W-1:0] wdata,
  output logic [NPORTS-1:0]        ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy,
  output logic                     ram_cs_b,
  output logic                     ram_oe_b,
  output logic                     ram_we_b,
  output logic [ADDR_W-1:0]        ram_adr,
  output logic [DATA_W-1:0]        ram_dat_out,
  output logic                     ram_dat_oe,
  input  logic [DATA_W-1:0]        ram_dat_in
);

  localparam int unsigned PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_we_q, op_we_d;
  logic [PTR_W-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0] last_q;

  logic [PTR_W-1:0] gnt_c;
  logic [PTR_W-1:0] idx_c;
  logic             any_c;

  logic [NPORTS-1:0] ack_d;
  logic [DATA_W-1:0] rdata_d;
  logic              busy_d;
  logic              cs_b_d;
  logic              oe_b_d;
  logic              we_b_d;
  logic [ADDR_W-1:0] adr_d;
  logic [DATA_W-1:0] dout_d;
  logic              doe_d;
  logic              grant_c;
  logic              finish_c;

  // Round-robin search: first requesting port starting after the last grant
  always_comb begin
    any_c = 1'b0;
    gnt_c = '0;
    idx_c = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      idx_c = PTR_W'((32'(last_q) + 32'd1 + i) % NPORTS);
      if (!any_c && req[idx_c]) begin
        any_c = 1'b1;
        gnt_c = idx_c;
      end
    end
  end

  assign grant_c  = (state_q == S_IDLE) && any_c;
  assign finish_c = (state_q == S_STROBE) && (cnt_q == '0);

  // State, wait counter, latched operation and round-robin pointer
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_we_q <= 1'b0;
      gnt_q   <= '0;
      last_q  <= PTR_W'(NPORTS - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_we_q <= op_we_d;
      gnt_q   <= gnt_d;
      if (grant_c) begin
        last_q <= gnt_c;
      end
    end
  end

  // Next state, strobe-length countdown and grant capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_we_d = op_we_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_c) begin
          state_d = S_SETUP;
          gnt_d   = gnt_c;
          op_we_d = we[gnt_c];
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = op_we_q ? CNT_W'(WR_WAIT) : CNT_W'(RD_WAIT);
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    cs_b_d  = (state_d == S_IDLE);
    oe_b_d  = !((state_d == S_STROBE) && !op_we_d);
    we_b_d  = !((state_d == S_STROBE) && op_we_d);
    doe_d   = op_we_d && (state_d != S_IDLE);
    busy_d  = (state_d != S_IDLE);
    ack_d   = '0;
    rdata_d = rdata;
    adr_d   = ram_adr;
    dout_d  = ram_dat_out;
    if (grant_c) begin
      adr_d  = addr[32'(gnt_c) * ADDR_W +: ADDR_W];
      dout_d = wdata[32'(gnt_c) * DATA_W +: DATA_W];
    end
    if (finish_c) begin
      ack_d[gnt_q] = 1'b1;
      if (!op_we_q) begin
        rdata_d = ram_dat_in;
      end
    end
  end

  // Output registers; reset releases every strobe at once
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ack         <= '0;
      rdata       <= '0;
      busy        <= 1'b0;
      ram_cs_b    <= 1'b1;
      ram_oe_b    <= 1'b1;
      ram_we_b    <= 1'b1;
      ram_adr     <= '0;
      ram_dat_out <= '0;
      ram_dat_oe  <= 1'b0;
    end else begin
      ack         <= ack_d;
      rdata       <= rdata_d;
      busy        <= busy_d;
      ram_cs_b    <= cs_b_d;
      ram_oe_b    <= oe_b_d;
      ram_we_b    <= we_b_d;
      ram_adr     <= adr_d;
      ram_dat_out <= dout_d;
      ram_dat_oe  <= doe_d;
    end
  end

endmodule

// File: tb/tb_sram_mp_ctrl.sv
// Bench for sram_mp_ctrl: a default build (RD_WAIT=WR_WAIT=1) and a
// rebuilt one (RD_WAIT=0, WR_WAIT=3), each with its own SRAM model.
module tb_sram_mp_ctrl;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 8;
  localparam int unsigned NP = 2;

  logic clk = 1'b0;
  logic reset_b;
  always #5 clk = ~clk;

  // default build signals
  logic [NP-1:0]    req_m, we_m, ack_m;
  logic [NP*AW-1:0] addr_m;
  logic [NP*DW-1:0] wdata_m;
  logic [DW-1:0]    rdata_m, dout_m, din_m;
  logic             busy_m, cs_m, oe_m, wb_m, doe_m;
  logic [AW-1:0]    adr_m;

  // rebuilt signals
  logic [NP-1:0]    req_r, we_r, ack_r;
  logic [NP*AW-1:0] addr_r;
  logic [NP*DW-1:0] wdata_r;
  logic [DW-1:0]    rdata_r, dout_r, din_r;
  logic             busy_r, cs_r, oe_r, wb_r, doe_r;
  logic [AW-1:0]    adr_r;

  logic [DW-1:0] mem_m [0:(1<<AW)-1];
  logic [DW-1:0] mem_r [0:(1<<AW)-1];

  sram_mp_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NPORTS(NP), .RD_WAIT(1), .WR_WAIT(1)) u_dut (
    .clk(clk), .reset_b(reset_b), .req(req_m), .we(we_m), .addr(addr_m), .wdata(wdata_m),
    .ack(ack_m), .rdata(rdata_m), .busy(busy_m), .ram_cs_b(cs_m), .ram_oe_b(oe_m),
    .ram_we_b(wb_m), .ram_adr(adr_m), .ram_dat_out(dout_m), .ram_dat_oe(doe_m),
    .ram_dat_in(din_m)
  );

  sram_mp_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NPORTS(NP), .RD_WAIT(0), .WR_WAIT(3)) u_dut_rb (
    .clk(clk), .reset_b(reset_b), .req(req_r), .we(we_r), .addr(addr_r), .wdata(wdata_r),
    .ack(ack_r), .rdata(rdata_r), .busy(busy_r), .ram_cs_b(cs_r), .ram_oe_b(oe_r),
    .ram_we_b(wb_r), .ram_adr(adr_r), .ram_dat_out(dout_r), .ram_dat_oe(doe_r),
    .ram_dat_in(din_r)
  );

  // asynchronous SRAM models
  assign din_m = (!cs_m && !oe_m) ? mem_m[adr_m] : '0;
  assign din_r = (!cs_r && !oe_r) ? mem_r[adr_r] : '0;
  always @(posedge wb_m) if (!cs_m) mem_m[adr_m] <= dout_m;
  always @(posedge wb_r) if (!cs_r) mem_r[adr_r] <= dout_r;

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;
  int acks    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // view of the instance currently driven by the access task
  logic          sel;
  logic [NP-1:0] v_ack;
  logic          v_oe, v_wb, v_doe;
  always_comb begin
    v_ack = sel ? ack_r : ack_m;
    v_oe  = sel ? oe_r  : oe_m;
    v_wb  = sel ? wb_r  : wb_m;
    v_doe = sel ? doe_r : doe_m;
  end

  // bus invariants, both builds, every cycle
  always @(negedge clk) begin
    if (reset_b === 1'b1) begin
      if (!oe_m && !wb_m) viol++;
      if (doe_m && !oe_m) viol++;
      if (!$onehot0(ack_m)) viol++;
      if (!oe_r && !wb_r) viol++;
      if (doe_r && !oe_r) viol++;
      if (!$onehot0(ack_r)) viol++;
      if (ack_m != '0) acks++;
      if (ack_r != '0) acks++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one access from IDLE; latency counted in edges from the sampling edge E0
  task automatic access(input logic inst, input int p, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int lat, output int oe_lo, output int we_lo,
                        output int doe_hi, output logic doe_at_ack);
    sel = inst;
    if (inst) begin
      we_r[p] = w; addr_r[p*AW +: AW] = a; wdata_r[p*DW +: DW] = d; req_r[p] = 1'b1;
    end else begin
      we_m[p] = w; addr_m[p*AW +: AW] = a; wdata_m[p*DW +: DW] = d; req_m[p] = 1'b1;
    end
    lat = -1; oe_lo = 0; we_lo = 0; doe_hi = 0; doe_at_ack = 1'b0;
    for (int n = 1; n <= 24 && lat < 0; n++) begin
      @(posedge clk);
      #1;
      if (!v_oe) oe_lo++;
      if (!v_wb) we_lo++;
      if (v_doe) doe_hi++;
      if (v_ack[p]) begin
        lat = n - 1;
        doe_at_ack = v_doe;
      end
    end
    if (inst) req_r[p] = 1'b0; else req_m[p] = 1'b0;
  endtask

  int   lat, oe_lo, we_lo, doe_hi;
  logic doe_at_ack;
  logic [3:0] order;
  int   cyc [4];
  logic [DW-1:0] dat [4];
  int   k, both, ack_in_rst;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_b = 1'b0; sel = 1'b0;
    req_m = '0; we_m = '0; addr_m = '0; wdata_m = '0;
    req_r = '0; we_r = '0; addr_r = '0; wdata_r = '0;
    mem_m[18'h000DE] = 8'h5A;
    mem_r[18'h000DE] = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs_oe_we_doe_busy", {cs_m, oe_m, wb_m, doe_m, busy_m}, 5'b11100);
    check("rst_ack", ack_m, 2'b00);
    check("rst_rdata", rdata_m, 8'h00);
    check("rst_adr", adr_m, 18'h0);
    @(negedge clk) reset_b = 1'b1;
    idle(2);

    // 1: port 0 read
    access(1'b0, 0, 1'b0, 18'h000DE, 8'h00, lat, oe_lo, we_lo, doe_hi, doe_at_ack);
    check("t1_latency", lat, 3);
    check("t1_oe_low_cycles", oe_lo, 2);
    check("t1_dat_oe_cycles", doe_hi, 0);
    check("t1_rdata", rdata_m, 8'h5A);
    idle(2);
    check("t1_rdata_held", rdata_m, 8'h5A);
    check("t1_busy_idle", busy_m, 1'b0);

    // 2: port 1 write to top address, then port 0 reads it back
    access(1'b0, 1, 1'b1, 18'h3FFFF, 8'h3C, lat, oe_lo, we_lo, doe_hi, doe_at_ack);
    check("t2_latency", lat, 3);
    check("t2_we_low_cycles", we_lo, 2);
    check("t2_oe_low_cycles", oe_lo, 0);
    check("t2_dat_oe_cycles", doe_hi, 4);
    check("t2_dat_held_at_ack", doe_at_ack, 1'b1);
    check("t2_mem", mem_m[18'h3FFFF], 8'h3C);
    idle(2);
    access(1'b0, 0, 1'b0, 18'h3FFFF, 8'h00, lat, oe_lo, we_lo, doe_hi, doe_at_ack);
    check("t2_readback", rdata_m, 8'h3C);
    idle(2);

    // 3: both ports read continuously; last grant was port 0 so port 1 leads
    sel = 1'b0;
    we_m = 2'b00;
    addr_m = {18'h3FFFF, 18'h000DE};
    req_m = 2'b11;
    k = 0; both = 0;
    for (int c = 0; c < 60 && k < 4; c++) begin
      @(posedge clk);
      #1;
      if (ack_m == 2'b11) both++;
      if (ack_m != 2'b00) begin
        order[3-k] = ack_m[1];
        cyc[k] = c;
        dat[k] = rdata_m;
        k++;
      end
    end
    req_m = 2'b00;
    check("t3_ack_count", k, 4);
    check("t3_grant_order", order, 4'b1010);
    check("t3_spacing_01", cyc[1] - cyc[0], 5);
    check("t3_spacing_12", cyc[2] - cyc[1], 5);
    check("t3_spacing_23", cyc[3] - cyc[2], 5);
    check("t3_data_p1", dat[0], 8'h3C);
    check("t3_data_p0", dat[1], 8'h5A);
    check("t3_both_acks", both, 0);
    idle(3);

    // 4: reset while a write strobe is low
    we_m[0] = 1'b1; addr_m[0 +: AW] = 18'h00100; wdata_m[0 +: DW] = 8'h77; req_m[0] = 1'b1;
    k = 0;
    while (wb_m && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("t4_reached_strobe", wb_m, 1'b0);
    #2;
    reset_b = 1'b0;
    #1;
    check("t4_cs_oe_we_doe_busy", {cs_m, oe_m, wb_m, doe_m, busy_m}, 5'b11100);
    check("t4_rdata_cleared", rdata_m, 8'h00);
    req_m = 2'b00;
    ack_in_rst = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (ack_m != 2'b00) ack_in_rst++;
    end
    @(negedge clk) reset_b = 1'b1;
    idle(1);
    check("t4_no_ack", {24'(ack_in_rst), 6'b0, ack_m}, 32'h0);
    access(1'b0, 1, 1'b0, 18'h000DE, 8'h00, lat, oe_lo, we_lo, doe_hi, doe_at_ack);
    check("t4_after_latency", lat, 3);
    check("t4_after_rdata", rdata_m, 8'h5A);
    idle(2);

    // 5: rebuilt with RD_WAIT=0, WR_WAIT=3
    access(1'b1, 0, 1'b0, 18'h000DE, 8'h00, lat, oe_lo, we_lo, doe_hi, doe_at_ack);
    check("t5_rd_latency", lat, 2);
    check("t5_rd_oe_low", oe_lo, 1);
    check("t5_rd_rdata", rdata_r, 8'h5A);
    idle(2);
    access(1'b1, 1, 1'b1, 18'h00042, 8'hA5, lat, oe_lo, we_lo, doe_hi, doe_at_ack);
    check("t5_wr_latency", lat, 5);
    check("t5_we_low_cycles", we_lo, 4);
    check("t5_dat_oe_cycles", doe_hi, 6);
    check("t5_dat_held_at_ack", {doe_at_ack, dout_r}, {1'b1, 8'hA5});
    idle(1);
    check("t5_dat_released", doe_r, 1'b0);
    check("t5_mem", mem_r[18'h00042], 8'hA5);
    idle(2);

    // 6: random traffic on both builds, invariants watched every cycle
    repeat (3000) begin
      @(negedge clk);
      req_m = NP'($urandom); we_m = NP'($urandom);
      addr_m = (NP*AW)'({$urandom, $urandom}); wdata_m = (NP*DW)'($urandom);
      req_r = NP'($urandom); we_r = NP'($urandom);
      addr_r = (NP*AW)'({$urandom, $urandom}); wdata_r = (NP*DW)'($urandom);
    end
    req_m = '0; req_r = '0;
    idle(12);
    check("t6_invariant_violations", viol, 0);
    check("t6_traffic_flowed", 32'(acks > 500), 1);
    check("t6_idle_at_end", {busy_m, busy_r, cs_m, cs_r}, 4'b0011);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
